encrypt_stream_unit: RTL and testbench

Streaming byte encryptor that produces ciphertext the configurable-mode `decrypt_unit` path recovers bit-exactly. It uses the same key schedule as that path and the inverse of its permute/XOR order: permute first, then XOR. It sits between a byte source and the link or decryptor. The block has a two-stage valid/ready pipeline with full backpressure, a runtime key load, a programmable key-rotation rate and a delivered-byte counter.

---
 rtl/encrypt_config.sv | 17 +
 rtl/encrypt_stream_unit.sv | 95 +++++++++
 tb/tb_encrypt_stream_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/encrypt_config.sv
// Default key bytes and bit permutation shared by the encrypt and decrypt paths.
package encrypt_config;

  localparam logic [7:0] XOR_KEY1 = 8'hC3;
  localparam logic [7:0] XOR_KEY2 = 8'h96;
  localparam logic [7:0] XOR_KEY3 = 8'hE7;

  localparam logic [2:0] PERM_0 = 3'd3;
  localparam logic [2:0] PERM_1 = 3'd6;
  localparam logic [2:0] PERM_2 = 3'd1;
  localparam logic [2:0] PERM_3 = 3'd5;
  localparam logic [2:0] PERM_4 = 3'd7;
  localparam logic [2:0] PERM_5 = 3'd0;
  localparam logic [2:0] PERM_6 = 3'd4;
  localparam logic [2:0] PERM_7 = 3'd2;

endpackage

// File: rtl/encrypt_stream_unit.sv
// Two-stage streaming byte encryptor: permute, then XOR with a rotating key byte.
// Valid/ready on both sides, runtime key load, programmable rotation rate, delivery counter.
module encrypt_stream_unit
  import encrypt_config::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [7:0]  k1,
  input  logic [7:0]  k2,
  input  logic [7:0]  k3,
  input  logic        key_load,
  input  logic [2:0]  rot_freq,
  output logic [7:0]  dout,
  output logic        v,
  input  logic        dout_ready,
  output logic [15:0] bytes_out
);

  // Input bit i lands at output position PERM_i, the inverse of the decryptor's gather.
  function automatic logic [7:0] permute(input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    p[PERM_0] = b[0];
    p[PERM_1] = b[1];
    p[PERM_2] = b[2];
    p[PERM_3] = b[3];
    p[PERM_4] = b[4];
    p[PERM_5] = b[5];
    p[PERM_6] = b[6];
    p[PERM_7] = b[7];
    return p;
  endfunction

  logic [23:0] curr_key;
  logic [2:0]  rcnt;
  logic [7:0]  data_p1;
  logic [7:0]  key_p1;
  logic        vld_p1;
  logic        accept;
  logic        s2_adv;

  assign s2_adv    = vld_p1 && (!v || dout_ready);
  assign din_ready = !rst && !key_load && (!vld_p1 || s2_adv);
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_key  <= {XOR_KEY2, XOR_KEY3, XOR_KEY1};
      rcnt      <= 3'd0;
      vld_p1    <= 1'b0;
      v         <= 1'b0;
      dout      <= 8'h00;
      bytes_out <= 16'd0;
    end else begin
      // key_load and accept are mutually exclusive because din_ready drops during a load
      if (key_load) begin
        curr_key <= {k2, k3, k1};
        rcnt     <= 3'd0;
      end else if (accept) begin
        if (rcnt == rot_freq) begin
          curr_key <= {curr_key[15:0], curr_key[23:16]};
          rcnt     <= 3'd0;
        end else begin
          rcnt <= rcnt + 3'd1;
        end
      end

      // stage 1 -> stage 2 boundary
      if (accept)      vld_p1 <= 1'b1;
      else if (s2_adv) vld_p1 <= 1'b0;

      if (s2_adv) begin
        dout <= permute(data_p1) ^ key_p1;
        v    <= 1'b1;
      end else if (dout_ready) begin
        v <= 1'b0;
      end

      if (key_load)              bytes_out <= 16'd0;
      else if (v && dout_ready)  bytes_out <= bytes_out + 16'd1;
    end
  end

  // stage 0 -> stage 1 boundary
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1 <= din;
      key_p1  <= curr_key[15:8];
    end
  end

endmodule

// File: tb/tb_encrypt_stream_unit.sv
// Directed self-checking bench for encrypt_stream_unit.
module tb_encrypt_stream_unit;
  import encrypt_config::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  k1 = 8'h00, k2 = 8'h00, k3 = 8'h00;
  logic        key_load = 1'b0;
  logic [2:0]  rot_freq = 3'd0;
  logic [7:0]  dout;
  logic        v;
  logic        dout_ready = 1'b1;
  logic [15:0] bytes_out;

  int n_asrt = 0;
  int n_fail = 0;
  logic [7:0] in_v [8];
  logic [7:0] ex_v [8];

  encrypt_stream_unit dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .k1(k1), .k2(k2), .k3(k3), .key_load(key_load), .rot_freq(rot_freq),
    .dout(dout), .v(v), .dout_ready(dout_ready), .bytes_out(bytes_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_keys(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    k1 = a; k2 = b; k3 = c;
    key_load = 1'b1;
    #1;
    chk("din_ready_during_load", din_ready, 16'd0);
    tick();
    key_load = 1'b0;
  endtask

  task automatic stream(input string tag, input int n_in, input int n_exp);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    dout_ready = 1'b1;
    while (got < n_exp && cyc < 40) begin
      if (idx < n_in) begin
        din = in_v[idx];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      #1;
      if (din_valid && din_ready) idx++;
      tick();
      cyc++;
      if (v) begin
        chk(tag, {8'h00, dout}, {8'h00, ex_v[got]});
        got++;
      end
    end
    din_valid = 1'b0;
    if (got < n_exp) chk({tag, "_timeout"}, got[15:0], n_exp[15:0]);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_v", v, 16'd0);
    chk("rst_dout", dout, 16'h00);
    chk("rst_bytes", bytes_out, 16'd0);
    chk("rst_din_ready", din_ready, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("din_ready_after_rst", din_ready, 16'd1);

    // Key sequence, rotate every byte, with latency check
    rot_freq = 3'd0;
    load_keys(8'h11, 8'h22, 8'h33);
    din = 8'h00; din_valid = 1'b1;
    tick(); chk("lat_v_n", v, 16'd0);
    tick(); chk("lat_v_n1", v, 16'd1); chk("seq0", dout, 16'h33);
    tick(); chk("seq1", dout, 16'h11);
    tick(); chk("seq2", dout, 16'h22);
    din_valid = 1'b0;
    tick(); chk("seq3", dout, 16'h33);
    tick(); chk("seq_v_drain", v, 16'd0); chk("seq_bytes", bytes_out, 16'd4);

    // Permutation with zero keys
    load_keys(8'h00, 8'h00, 8'h00);
    in_v = '{8'h01, 8'h80, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    ex_v = '{8'h08, 8'h04, 8'h40, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    stream("perm", 4, 4);
    tick();

    // Slow rotation
    rot_freq = 3'd2;
    load_keys(8'h11, 8'h22, 8'h33);
    in_v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ex_v = '{8'h33, 8'h33, 8'h33, 8'h11, 8'h11, 8'h11, 8'h22, 8'h00};
    stream("slow_rot", 7, 7);
    tick();

    // Backpressure: two bytes absorbed, output frozen, then drained in order
    rot_freq = 3'd0;
    load_keys(8'h11, 8'h22, 8'h33);
    dout_ready = 1'b0;
    din = 8'h01; din_valid = 1'b1;
    tick(); chk("bp_ready_s1", din_ready, 16'd1);
    din = 8'h80;
    tick(); chk("bp_v", v, 16'd1); chk("bp_dout0", dout, 16'h3B); chk("bp_full", din_ready, 16'd0);
    din = 8'h02;
    tick(); chk("bp_hold_dout", dout, 16'h3B); chk("bp_hold_ready", din_ready, 16'd0);
    tick(); chk("bp_hold_dout2", dout, 16'h3B); chk("bp_hold_v", v, 16'd1);
    dout_ready = 1'b1;
    #1; chk("bp_ready_release", din_ready, 16'd1);
    tick(); chk("bp_dout1", dout, 16'h15);
    din = 8'h00;
    tick(); chk("bp_dout2", dout, 16'h62);
    din_valid = 1'b0;
    tick(); chk("bp_dout3", dout, 16'h33);
    tick(); chk("bp_drain_v", v, 16'd0); chk("bp_bytes", bytes_out, 16'd4);

    // Key load while both stages are full
    dout_ready = 1'b0;
    din = 8'h00; din_valid = 1'b1;
    tick();
    tick(); chk("kl_dout_old", dout, 16'h11); chk("kl_full", din_ready, 16'd0);
    k1 = 8'h00; k2 = 8'h00; k3 = 8'h5A;
    key_load = 1'b1; dout_ready = 1'b1;
    #1; chk("kl_ready_low", din_ready, 16'd0);
    tick();
    key_load = 1'b0;
    chk("kl_inflight_old_key", dout, 16'h22);
    chk("kl_bytes_clear", bytes_out, 16'd0);
    #1; chk("kl_ready_after", din_ready, 16'd1);
    tick(); chk("kl_v_gap", v, 16'd0); chk("kl_bytes1", bytes_out, 16'd1);
    din_valid = 1'b0;
    tick(); chk("kl_new_key", dout, 16'h5A); chk("kl_new_v", v, 16'd1);
    tick(); chk("kl_bytes2", bytes_out, 16'd2);

    // Asynchronous reset with a stalled pipeline
    dout_ready = 1'b0;
    din = 8'h00; din_valid = 1'b1;
    tick();
    tick();
    din_valid = 1'b0;
    chk("ar_v_before", v, 16'd1);
    rst = 1'b1;
    #1;
    chk("ar_v", v, 16'd0);
    chk("ar_dout", dout, 16'h00);
    chk("ar_bytes", bytes_out, 16'd0);
    chk("ar_din_ready", din_ready, 16'd0);
    tick();
    rst = 1'b0;
    #1; chk("ar_ready_release", din_ready, 16'd1);
    in_v[0] = 8'h00;
    ex_v[0] = XOR_KEY3;
    stream("ar_default_key", 1, 1);
    tick();

    // Byte counter wrap
    load_keys(8'h00, 8'h00, 8'h00);
    din = 8'h00; din_valid = 1'b1;
    repeat (65536) tick();
    din_valid = 1'b0;
    tick(); chk("wrap_ffff", bytes_out, 16'hFFFF);
    tick(); chk("wrap_zero", bytes_out, 16'h0000); chk("wrap_v", v, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
